wb_test_rams_slave: RTL and testbench
=====================================

WB_TEST_RAMS_SLAVE -- requirements
Module: wb_test_rams_slave

Interface
REQ-001 SHALL have parameter MEM1K_WORDS, default 256: mem1k depth in 32-bit words.
REQ-002 SHALL have parameter MEM2K_WORDS, default 512: mem2k depth in 32-bit words (1024 x 16-bit on the user port).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have the following ports:
- wb_clk_i  in  1  sole clock; all logic on rising edge
- rst_i  in  1  synchronous reset, active high
- wb_addr_i  in  11  Wishbone word address
- wb_data_i  in  32  write data
- wb_data_o  out  32  read data
- wb_sel_i  in  4  byte selects
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  classic Wishbone controls
- wb_ack_o  out  1  acknowledge
- rams_mem1k_addr_i  in  8  user word address
- rams_mem1k_data_i  in  32  user write data
- rams_mem1k_data_o  out  32  user read data
- rams_mem1k_rd_i, rams_mem1k_wr_i  in  1 each  user read/write strobes
- rams_mem1k_bwsel_i  in  4  user byte enables
- rams_mem2k_addr_i  in  10  user half-word address
- rams_mem2k_data_o  out  16  user read data
- rams_mem2k_rd_i  in  1  user read strobe (read-only port)

Function
REQ-005 SHALL decode wb_addr_i[10]=0 as mem1k and wb_addr_i[10]=1 as mem2k.
REQ-006 SHALL index mem1k with wb_addr_i[7:0]; bits [9:8] are ignored, so the 256 words mirror 4 times (byte offsets 0x000-0xFFF).
REQ-007 SHALL index mem2k with wb_addr_i[8:0]; bit 9 is ignored, so the 512 words mirror twice.
REQ-008 SHALL assert wb_ack_o as a one-cycle pulse on the second rising edge after cyc&stb is first sampled high (1 wait state), for both reads and writes.
REQ-009 SHALL ignore stb during the ack cycle; back-to-back accesses start at the next edge.
REQ-010 SHALL commit bus writes in the ack cycle, writing only the bytes enabled by wb_sel_i.
REQ-011 SHALL present wb_data_o valid in the ack cycle; wb_data_o is 0 at all other times.
REQ-012 SHALL abort the access with no ack and no write if cyc or stb drops before ack.
REQ-013 SHALL write mem1k from the user port on the clock edge where rams_mem1k_wr_i=1, enabling bytes per rams_mem1k_bwsel_i (bit 3 = [31:24]).
REQ-014 SHALL register rams_mem1k_data_o one cycle after rams_mem1k_rd_i=1 and hold it otherwise.
REQ-015 SHALL register rams_mem2k_data_o one cycle after rams_mem2k_rd_i=1: addr[0]=0 returns word addr[9:1] bits [15:0], addr[0]=1 returns bits [31:16]; held otherwise.
REQ-016 SHALL let the user port win when bus and user writes to the same mem1k word occur on the same edge.
REQ-017 SHALL return old data (read-first) on a same-edge read and write to the same address, on either port.

Reset
REQ-018 SHALL clear wb_ack_o, wb_data_o, rams_mem1k_data_o and rams_mem2k_data_o to 0 and return bus state to idle while rst_i=1.
REQ-019 SHALL drop any access in progress when reset is asserted, with no ack and no write.
REQ-020 SHALL leave RAM contents unaffected by reset.

Structure
REQ-021 SHALL place the following in a shared package: BASE_RAMS_MEM1K=0x0000, BASE_RAMS_MEM2K=0x1000 (byte addresses), SIZE_RAMS_MEM1K=256, SIZE_RAMS_MEM2K=512, and the address widths.
REQ-022 SHALL implement storage as one sub-module, wb_test_rams_dpram: a parameterized 32-bit dual-port RAM with byte enables and read-first behaviour, instantiated twice.

Verification
REQ-023 Bus write 0xDEADBEEF to byte 0x0, 0xCAFECAFE to 0x4, 0xFACEDEAD to 0x200 -> bus reads return the same values; each ack arrives 2 cycles after stb.
REQ-024 Bus write 0x55555555 to byte 0x10, then 0xAAAAAAAA to byte 0x410 -> read of 0x10 returns 0xAAAAAAAA (mirror).
REQ-025 User port writes 257-i to addresses i=0..255 with bwsel=0xF -> bus reads of byte 0x0 and 0x4 return 257 and 256.
REQ-026 Bus write 0x11223344 to byte 0x1000+8 -> mem2k user reads at addr 4 and 5 return 0x3344 and 0x1122 one cycle after rd_i.
REQ-027 Bus write with wb_sel_i=0b0010 of 0xFFFFFFFF over 0x00000000 -> word reads 0x0000FF00; cyc dropped after 1 cycle -> no ack, memory unchanged.
REQ-028 rst_i asserted mid-read -> no ack, all outputs 0 next cycle, previously written data still readable.

Source files
------------

// File: rtl/wb_test_rams_pkg.sv
// ============================================================================
// Module      : wb_test_rams_pkg
// Description : Address map, widths and bus-state encoding shared by the
//               Wishbone test-RAM slave and its storage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_test_rams_pkg;

    localparam logic [15:0] BASE_RAMS_MEM1K = 16'h0000;
    localparam logic [15:0] BASE_RAMS_MEM2K = 16'h1000;
    localparam int          SIZE_RAMS_MEM1K = 256;
    localparam int          SIZE_RAMS_MEM2K = 512;

    localparam int WB_AW         = 11;
    localparam int WB_DW         = 32;
    localparam int MEM1K_AW      = 8;
    localparam int MEM2K_AW      = 9;
    localparam int MEM2K_USER_AW = 10;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_WAIT = 2'd1,
        BUS_ACK  = 2'd2
    } bus_state_t;

    // mem2k lives at byte 0x1000, i.e. word-address bit 10
    function automatic logic is_mem2k(input logic [WB_AW-1:0] a);
        return a[WB_AW-1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_test_rams_dpram.sv
// ============================================================================
// Module      : wb_test_rams_dpram
// Description : 32-bit true dual-port RAM, byte enables, read-first, with
//               registered read data that is cleared by reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_test_rams_dpram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_a_en,
    input  logic          i_a_we,
    input  logic [3:0]    i_a_be,
    input  logic [AW-1:0] i_a_addr,
    input  logic [31:0]   i_a_wdata,
    output logic [31:0]   o_a_rdata,
    input  logic          i_b_en,
    input  logic          i_b_we,
    input  logic [3:0]    i_b_be,
    input  logic [AW-1:0] i_b_addr,
    input  logic [31:0]   i_b_wdata,
    output logic [31:0]   o_b_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_a_rdata;
    logic [31:0] r_b_rdata;

    // Port B is written after port A so it wins a same-word collision
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_a_we && i_a_be[b]) begin
                r_mem[i_a_addr][8*b +: 8] <= i_a_wdata[8*b +: 8];
            end
        end
        for (int b = 0; b < 4; b++) begin
            if (i_b_we && i_b_be[b]) begin
                r_mem[i_b_addr][8*b +: 8] <= i_b_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_rdata <= 32'd0;
            r_b_rdata <= 32'd0;
        end else begin
            if (i_a_en) r_a_rdata <= r_mem[i_a_addr];
            if (i_b_en) r_b_rdata <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule

`default_nettype wire

// File: rtl/wb_test_rams_slave.sv
// ============================================================================
// Module      : wb_test_rams_slave
// Description : Wishbone classic slave (1 wait state) fronting two test RAMs,
//               each with an independent user port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_test_rams_slave
    import wb_test_rams_pkg::*;
#(
    parameter int MEM1K_WORDS = 256,
    parameter int MEM2K_WORDS = 512
) (
    input  logic                     wb_clk_i,
    input  logic                     rst_i,
    input  logic [WB_AW-1:0]         wb_addr_i,
    input  logic [31:0]              wb_data_i,
    output logic [31:0]              wb_data_o,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    output logic                     wb_ack_o,
    input  logic [MEM1K_AW-1:0]      rams_mem1k_addr_i,
    input  logic [31:0]              rams_mem1k_data_i,
    output logic [31:0]              rams_mem1k_data_o,
    input  logic                     rams_mem1k_rd_i,
    input  logic                     rams_mem1k_wr_i,
    input  logic [3:0]               rams_mem1k_bwsel_i,
    input  logic [MEM2K_USER_AW-1:0] rams_mem2k_addr_i,
    output logic [15:0]              rams_mem2k_data_o,
    input  logic                     rams_mem2k_rd_i
);

    bus_state_t  r_state;
    bus_state_t  w_state_nxt;
    logic        r_m2k_hi;
    logic        w_req;
    logic        w_ack;
    logic        w_sel_2k;
    logic        w_bus_wr;
    logic [31:0] w_q1k_a;
    logic [31:0] w_q2k_a;
    logic [31:0] w_q2k_b;
    logic        w_unused;

    assign w_req    = wb_cyc_i & wb_stb_i;
    assign w_ack    = (r_state == BUS_ACK);
    assign w_sel_2k = is_mem2k(wb_addr_i);
    // Write lands on the edge that closes the ack cycle
    assign w_bus_wr = w_ack & w_req & wb_we_i;
    assign w_unused = ^wb_addr_i[9:8];

    always_ff @(posedge wb_clk_i) begin
        if (rst_i) begin
            r_state <= BUS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BUS_IDLE: if (w_req) w_state_nxt = BUS_WAIT;
            BUS_WAIT: w_state_nxt = w_req ? BUS_ACK : BUS_IDLE;
            BUS_ACK:  w_state_nxt = BUS_IDLE;
            default:  w_state_nxt = BUS_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst_i) begin
            r_m2k_hi <= 1'b0;
        end else if (rams_mem2k_rd_i) begin
            r_m2k_hi <= rams_mem2k_addr_i[0];
        end
    end

    wb_test_rams_dpram #(
        .DEPTH (MEM1K_WORDS),
        .AW    (MEM1K_AW)
    ) u_mem1k (
        .i_clk     (wb_clk_i),
        .i_rst     (rst_i),
        .i_a_en    (1'b1),
        .i_a_we    (w_bus_wr & ~w_sel_2k),
        .i_a_be    (wb_sel_i),
        .i_a_addr  (wb_addr_i[MEM1K_AW-1:0]),
        .i_a_wdata (wb_data_i),
        .o_a_rdata (w_q1k_a),
        .i_b_en    (rams_mem1k_rd_i),
        .i_b_we    (rams_mem1k_wr_i),
        .i_b_be    (rams_mem1k_bwsel_i),
        .i_b_addr  (rams_mem1k_addr_i),
        .i_b_wdata (rams_mem1k_data_i),
        .o_b_rdata (rams_mem1k_data_o)
    );

    wb_test_rams_dpram #(
        .DEPTH (MEM2K_WORDS),
        .AW    (MEM2K_AW)
    ) u_mem2k (
        .i_clk     (wb_clk_i),
        .i_rst     (rst_i),
        .i_a_en    (1'b1),
        .i_a_we    (w_bus_wr & w_sel_2k),
        .i_a_be    (wb_sel_i),
        .i_a_addr  (wb_addr_i[MEM2K_AW-1:0]),
        .i_a_wdata (wb_data_i),
        .o_a_rdata (w_q2k_a),
        .i_b_en    (rams_mem2k_rd_i),
        .i_b_we    (1'b0),
        .i_b_be    (4'h0),
        .i_b_addr  (rams_mem2k_addr_i[MEM2K_USER_AW-1:1]),
        .i_b_wdata (32'd0),
        .o_b_rdata (w_q2k_b)
    );

    assign wb_ack_o          = w_ack;
    assign wb_data_o         = w_ack ? (w_sel_2k ? w_q2k_a : w_q1k_a) : 32'd0;
    assign rams_mem2k_data_o = r_m2k_hi ? w_q2k_b[31:16] : w_q2k_b[15:0];

endmodule

`default_nettype wire

// File: tb/tb_wb_test_rams_slave.sv
// ============================================================================
// Module      : tb_wb_test_rams_slave
// Description : Self-checking bench: directed scenarios plus random traffic
//               against an array-based memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_test_rams_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] wb_addr;
    logic [31:0] wb_wdat;
    logic [31:0] wb_rdat;
    logic [3:0]  wb_sel;
    logic        wb_cyc, wb_stb, wb_we;
    logic        wb_ack;
    logic [7:0]  m1_addr;
    logic [31:0] m1_wdat, m1_rdat;
    logic        m1_rd, m1_wr;
    logic [3:0]  m1_be;
    logic [9:0]  m2_addr;
    logic [15:0] m2_rdat;
    logic        m2_rd;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m1k [256];
    logic [31:0] m2k [512];

    always #5 clk = ~clk;

    wb_test_rams_slave dut (
        .wb_clk_i           (clk),
        .rst_i              (rst),
        .wb_addr_i          (wb_addr),
        .wb_data_i          (wb_wdat),
        .wb_data_o          (wb_rdat),
        .wb_sel_i           (wb_sel),
        .wb_cyc_i           (wb_cyc),
        .wb_stb_i           (wb_stb),
        .wb_we_i            (wb_we),
        .wb_ack_o           (wb_ack),
        .rams_mem1k_addr_i  (m1_addr),
        .rams_mem1k_data_i  (m1_wdat),
        .rams_mem1k_data_o  (m1_rdat),
        .rams_mem1k_rd_i    (m1_rd),
        .rams_mem1k_wr_i    (m1_wr),
        .rams_mem1k_bwsel_i (m1_be),
        .rams_mem2k_addr_i  (m2_addr),
        .rams_mem2k_data_o  (m2_rdat),
        .rams_mem2k_rd_i    (m2_rd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Model: word address bit 10 picks the RAM, upper index bits mirror
    function automatic logic [31:0] model_rd(input logic [10:0] w);
        return w[10] ? m2k[w[8:0]] : m1k[w[7:0]];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_wr(input logic [10:0] w, input logic [31:0] d, input logic [3:0] be);
        if (w[10]) m2k[w[8:0]] = merge(m2k[w[8:0]], d, be);
        else       m1k[w[7:0]] = merge(m1k[w[7:0]], d, be);
    endtask

    task automatic bus_access(input logic we, input logic [10:0] w, input logic [31:0] d,
                              input logic [3:0] be, output logic [31:0] rd);
        int n;
        @(negedge clk);
        wb_addr = w; wb_wdat = d; wb_sel = be; wb_we = we;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        n = 0;
        while (n < 6 && wb_ack !== 1'b1) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (n == 1) check("data_idle", wb_rdat, 32'd0);
        end
        check("ack_lat", n, 2);
        rd = wb_rdat;
        @(posedge clk); @(negedge clk);
        check("ack_pulse", {31'd0, wb_ack}, 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        if (we) model_wr(w, d, be);
    endtask

    task automatic bus_write(input logic [10:0] w, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] dummy;
        bus_access(1'b1, w, d, be, dummy);
    endtask

    task automatic bus_read(input string tag, input logic [10:0] w);
        logic [31:0] rd;
        bus_access(1'b0, w, 32'd0, 4'h0, rd);
        check(tag, rd, model_rd(w));
    endtask

    task automatic user_wr1k(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        m1_addr = a; m1_wdat = d; m1_be = be; m1_wr = 1'b1;
        @(posedge clk); @(negedge clk);
        m1_wr = 1'b0;
        m1k[a] = merge(m1k[a], d, be);
    endtask

    task automatic user_rd1k(input logic [7:0] a);
        @(negedge clk);
        m1_addr = a; m1_rd = 1'b1;
        @(posedge clk); @(negedge clk);
        m1_rd = 1'b0;
        check("u1k_rd", m1_rdat, m1k[a]);
    endtask

    task automatic user_rd2k(input logic [9:0] a);
        logic [31:0] w;
        @(negedge clk);
        m2_addr = a; m2_rd = 1'b1;
        @(posedge clk); @(negedge clk);
        m2_rd = 1'b0;
        w = m2k[a[9:1]];
        check("u2k_rd", {16'd0, m2_rdat}, {16'd0, a[0] ? w[31:16] : w[15:0]});
    endtask

    initial begin
        logic [31:0] rd, old;
        logic [31:0] r;
        int n;
        rst = 1'b1;
        wb_addr = '0; wb_wdat = '0; wb_sel = '0; wb_cyc = 0; wb_stb = 0; wb_we = 0;
        m1_addr = '0; m1_wdat = '0; m1_rd = 0; m1_wr = 0; m1_be = '0;
        m2_addr = '0; m2_rd = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_data", wb_rdat, 32'd0);
        check("rst_u1k", m1_rdat, 32'd0);
        check("rst_u2k", {16'd0, m2_rdat}, 32'd0);
        rst = 1'b0;

        // Fill mem1k from the user port, mem2k from the bus
        for (int i = 0; i < 256; i++) user_wr1k(i[7:0], 32'(257 - i), 4'hF);
        for (int i = 0; i < 512; i++) bus_write(11'h400 | 11'(i), $urandom, 4'hF);
        bus_read("fill_rd0", 11'h000);
        check("fill_257", model_rd(11'h000), 32'd257);
        bus_read("fill_rd1", 11'h001);
        check("fill_256", model_rd(11'h001), 32'd256);

        bus_write(11'h000, 32'hDEADBEEF, 4'hF);
        bus_write(11'h001, 32'hCAFECAFE, 4'hF);
        bus_write(11'h080, 32'hFACEDEAD, 4'hF);
        bus_access(1'b0, 11'h000, 0, 0, rd); check("rw_0", rd, 32'hDEADBEEF);
        bus_access(1'b0, 11'h001, 0, 0, rd); check("rw_4", rd, 32'hCAFECAFE);
        bus_access(1'b0, 11'h080, 0, 0, rd); check("rw_200", rd, 32'hFACEDEAD);

        bus_write(11'h004, 32'h55555555, 4'hF);
        bus_write(11'h104, 32'hAAAAAAAA, 4'hF);
        bus_access(1'b0, 11'h004, 0, 0, rd); check("mirror", rd, 32'hAAAAAAAA);

        bus_write(11'h402, 32'h11223344, 4'hF);
        user_rd2k(10'd4); check("m2k_lo", {16'd0, m2_rdat}, 32'h3344);
        user_rd2k(10'd5); check("m2k_hi", {16'd0, m2_rdat}, 32'h1122);
        @(negedge clk); m2_addr = 10'd4;
        @(negedge clk); check("m2k_hold", {16'd0, m2_rdat}, 32'h1122);

        bus_write(11'h020, 32'h00000000, 4'hF);
        bus_write(11'h020, 32'hFFFFFFFF, 4'b0010);
        bus_access(1'b0, 11'h020, 0, 0, rd); check("bytesel", rd, 32'h0000FF00);

        // Abort: cyc drops after one cycle
        @(negedge clk);
        wb_addr = 11'h020; wb_wdat = 32'h12345678; wb_sel = 4'hF; wb_we = 1; wb_cyc = 1; wb_stb = 1;
        @(posedge clk); @(negedge clk);
        wb_cyc = 0;
        r = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            r = r | {31'd0, wb_ack};
        end
        check("abort_ack", r, 32'd0);
        wb_stb = 0; wb_we = 0;
        bus_access(1'b0, 11'h020, 0, 0, rd); check("abort_mem", rd, 32'h0000FF00);

        // Same-edge bus and user write to one word, with user read-first
        old = m1k[8'h30];
        @(negedge clk);
        wb_addr = 11'h030; wb_wdat = 32'hA5A5A5A5; wb_sel = 4'hF; wb_we = 1; wb_cyc = 1; wb_stb = 1;
        n = 0;
        while (n < 6 && wb_ack !== 1'b1) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        check("col_lat", n, 2);
        m1_addr = 8'h30; m1_wdat = 32'h01020304; m1_be = 4'h3; m1_wr = 1; m1_rd = 1;
        @(posedge clk); @(negedge clk);
        wb_cyc = 0; wb_stb = 0; wb_we = 0; m1_wr = 0; m1_rd = 0;
        check("rd_first", m1_rdat, old);
        m1k[8'h30] = 32'hA5A50304;
        bus_read("collide", 11'h030);

        // Reset in the middle of a read
        user_rd1k(8'd5);
        user_rd2k(10'd4);
        @(negedge clk);
        wb_addr = 11'h000; wb_we = 0; wb_cyc = 1; wb_stb = 1;
        @(posedge clk); @(negedge clk);
        rst = 1;
        @(posedge clk); @(negedge clk);
        check("rst_mid_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_mid_dat", wb_rdat, 32'd0);
        check("rst_mid_u1k", m1_rdat, 32'd0);
        check("rst_mid_u2k", {16'd0, m2_rdat}, 32'd0);
        wb_cyc = 0; wb_stb = 0; rst = 0;
        @(posedge clk); @(negedge clk);
        check("rst_post_ack", {31'd0, wb_ack}, 32'd0);
        bus_read("rst_keep", 11'h000);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0: bus_write(11'($urandom), $urandom, 4'($urandom));
                1: bus_read("rnd_bus", 11'($urandom));
                2: user_wr1k(8'($urandom), $urandom, 4'($urandom));
                3: user_rd1k(8'($urandom));
                default: user_rd2k(10'($urandom));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
